// File: rtl/tia_cx_reader.sv
// tia_cx_reader
//   CPU-facing read/clear side of the TIA collision latches. Each pixel strobe
//   ORs the pairwise overlap of the six visible objects into 15 sticky bits.
//   The CPU reads them as eight 2-bit registers in D7/D6. Writing CXCLR wipes
//   all of them.
//
// Ports
//   clk       system clock, all state on posedge
//   reset_n   asynchronous active-low reset
//   pix_en    pixel strobe qualifying collision sampling
//   obj[5:0]  {pf,bl,m1,m0,p1,p0} visibility for this pixel
//   rd_req    one-cycle CPU read request (accepted when addr[3]=0)
//   wr_req    one-cycle CPU write request (only CXCLR_ADDR has an effect)
//   addr      CPU register address
//   rd_valid  one-cycle pulse, the cycle after an accepted read
//   rd_data   {D7,D6,6'b0}, held while rd_valid is low
module tia_cx_reader #(
    parameter int                 ADDR_W     = 6,
    parameter logic [ADDR_W-1:0]  CXCLR_ADDR = 'h2C
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic [5:0]        obj,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    output logic              rd_valid,
    output logic [7:0]        rd_data
);

    // Latch bit positions. They are ordered so that registers 0..5 read
    // {cx[2i], cx[2i+1]} directly.
    localparam int M0P1 = 0,  M0P0 = 1,  M1P0 = 2,  M1P1 = 3;
    localparam int P0PF = 4,  P0BL = 5,  P1PF = 6,  P1BL = 7;
    localparam int M0PF = 8,  M0BL = 9,  M1PF = 10, M1BL = 11;
    localparam int BLPF = 12, P0P1 = 13, M0M1 = 14;

    logic p0, p1, m0, m1, bl, pf;
    logic [14:0] hit;
    logic [14:0] cx_q, cx_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_acc, clr;
    logic [1:0]  rd_sel;

    assign {pf, bl, m1, m0, p1, p0} = obj;

    always_comb begin
        hit       = '0;
        hit[M0P1] = m0 & p1;
        hit[M0P0] = m0 & p0;
        hit[M1P0] = m1 & p0;
        hit[M1P1] = m1 & p1;
        hit[P0PF] = p0 & pf;
        hit[P0BL] = p0 & bl;
        hit[P1PF] = p1 & pf;
        hit[P1BL] = p1 & bl;
        hit[M0PF] = m0 & pf;
        hit[M0BL] = m0 & bl;
        hit[M1PF] = m1 & pf;
        hit[M1BL] = m1 & bl;
        hit[BLPF] = bl & pf;
        hit[P0P1] = p0 & p1;
        hit[M0M1] = m0 & m1;
    end

    assign clr    = wr_req && (addr == CXCLR_ADDR);
    assign rd_acc = rd_req && !addr[3];

    // The read mux looks at cx_q. A read therefore returns the pre-update
    // snapshot, even when a clear or a new collision happens in the same
    // cycle.
    always_comb begin
        rd_sel = 2'b00;
        case (addr[2:0])
            3'd0: rd_sel = {cx_q[M0P1], cx_q[M0P0]};
            3'd1: rd_sel = {cx_q[M1P0], cx_q[M1P1]};
            3'd2: rd_sel = {cx_q[P0PF], cx_q[P0BL]};
            3'd3: rd_sel = {cx_q[P1PF], cx_q[P1BL]};
            3'd4: rd_sel = {cx_q[M0PF], cx_q[M0BL]};
            3'd5: rd_sel = {cx_q[M1PF], cx_q[M1BL]};
            3'd6: rd_sel = {cx_q[BLPF], 1'b0};
            default: rd_sel = {cx_q[P0P1], cx_q[M0M1]};
        endcase
    end

    always_comb begin
        cx_d       = cx_q;
        rd_valid_d = rd_acc;
        rd_data_d  = rd_data_q;
        // A clear wins over a collision sampled in the same cycle.
        if (clr)
            cx_d = '0;
        else if (pix_en)
            cx_d = cx_q | hit;
        if (rd_acc)
            rd_data_d = {rd_sel, 6'b0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            cx_q       <= cx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_tia_cx_reader.sv
// tb_tia_cx_reader
//   Scoreboard bench for tia_cx_reader. The driver runs directed and random
//   cycles against a collision-matrix reference model and queues the expected
//   read responses. A negedge monitor pops the queue on rd_valid. It checks
//   timing, data, missing pulses and rd_data hold.
module tb_tia_cx_reader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pix_en;
    logic [5:0] obj;
    logic       rd_req;
    logic       wr_req;
    logic [5:0] addr;
    logic       rd_valid;
    logic [7:0] rd_data;

    tia_cx_reader #(.ADDR_W(6), .CXCLR_ADDR(6'h2C)) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .obj(obj),
        .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         vectors = 0;
    int         errors = 0;
    logic [7:0] last_data = 8'h00;

    // Model: symmetric object-overlap matrix. Object ids are
    // P0=0 P1=1 M0=2 M1=3 BL=4 PF=5, matching the obj bit order.
    bit coll[6][6];
    // Object pair for D7 and D6 of each register (-1 = constant 0).
    int d7a[8] = '{2, 3, 0, 1, 2, 3, 4, 0};
    int d7b[8] = '{1, 0, 5, 5, 5, 5, 5, 1};
    int d6a[8] = '{2, 3, 0, 1, 2, 3, -1, 2};
    int d6b[8] = '{0, 1, 4, 4, 4, 4, -1, 3};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_read(input int a);
        bit d7, d6;
        d7 = coll[d7a[a]][d7b[a]];
        d6 = 1'b0;
        if (d6a[a] >= 0) d6 = coll[d6a[a]][d6b[a]];
        return {d7, d6, 6'b0};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                coll[i][j] = 1'b0;
    endtask

    // One bus/pixel cycle. Inputs are applied at negedge and take effect on
    // the next posedge.
    task automatic cycle(input bit pe, input logic [5:0] o, input bit rd,
                         input bit wr, input logic [5:0] a);
        exp_t e;
        @(negedge clk);
        pix_en = pe; obj = o; rd_req = rd; wr_req = wr; addr = a;
        if (rd && !a[3]) begin
            e.due  = cyc + 1;
            e.data = model_read(int'(a[2:0]));
            sb.push_back(e);
        end
        if (wr && a == 6'h2C)
            model_clear();
        else if (pe)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++)
                    if (i != j && o[i] && o[j]) coll[i][j] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 6'h00, 0, 0, 6'h00);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) cycle(0, 6'h00, 1, 0, 6'(a));
    endtask

    task automatic clear();
        cycle(0, 6'h00, 0, 1, 6'h2C);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            exp_t e;
            if (rd_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d got rd_data=%h, no read pending", cyc, rd_data);
                end else begin
                    e = sb.pop_front();
                    if (e.due != cyc || rd_data !== e.data) begin
                        errors++;
                        $display("FAIL read_data cyc=%0d got %h at cyc %0d, expected %h at cyc %0d",
                                 cyc, rd_data, cyc, e.data, e.due);
                    end
                    last_data = e.data;
                end
            end else begin
                vectors++;
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    errors++;
                    $display("FAIL missing_valid cyc=%0d got rd_valid=0, expected pulse with %h", cyc, e.data);
                end else if (rd_data !== last_data) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got rd_data=%h, expected held %h", cyc, rd_data, last_data);
                end
            end
        end
    end

    initial begin
        logic [5:0] a, o;
        int r;
        reset_n = 1'b0; pix_en = 0; obj = 0; rd_req = 0; wr_req = 0; addr = 0;
        model_clear();
        #2;
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got valid=%b data=%h, expected 0/00", rd_valid, rd_data);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Reads after reset are all zero.
        read_all(); idle(2);
        // Only P0P1 is set.
        cycle(1, 6'b000011, 0, 0, 6'h00); read_all(); idle(2);
        // All objects overlap, so every pair is set.
        clear(); cycle(1, 6'h3F, 0, 0, 6'h00); read_all(); idle(2);
        // A clear during a live collision, then re-set on the next pixel.
        clear(); cycle(1, 6'b000101, 0, 0, 6'h00);
        cycle(1, 6'b000101, 0, 1, 6'h2C);
        cycle(1, 6'b000101, 1, 0, 6'h00);
        cycle(0, 6'h00, 1, 0, 6'h00);
        cycle(0, 6'h00, 0, 1, 6'h2C);
        cycle(0, 6'h00, 1, 0, 6'h00); idle(2);
        // With pix_en low, the latches do not move.
        clear();
        for (int i = 0; i < 100; i++) cycle(0, 6'h3F, 1, 0, 6'($urandom_range(0, 7)));
        cycle(0, 6'h00, 1, 0, 6'h08); idle(2);
        // Read P0PF, clear next cycle, then read it again.
        clear(); cycle(1, 6'b100001, 0, 0, 6'h00);
        cycle(0, 6'h00, 1, 0, 6'h02); clear(); cycle(0, 6'h00, 1, 0, 6'h02); idle(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       a = {3'b000, 3'($urandom)};
            else if (r == 6) a = 6'h2C;
            else if (r == 7) a = {3'b001, 3'($urandom)};
            else             a = 6'($urandom);
            o = 6'($urandom) & 6'($urandom) & 6'($urandom);
            cycle($urandom_range(0, 1) == 1, o, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 2, a);
        end
        idle(3);

        // Assert reset while an accepted read is still in flight.
        cycle(1, 6'h3F, 0, 0, 6'h00);
        @(negedge clk);
        pix_en = 0; obj = 0; wr_req = 0; rd_req = 1; addr = 6'h00;
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_read got valid=%b data=%h, expected 0/00", rd_valid, rd_data);
        end
        @(negedge clk);
        rd_req = 0;
        model_clear();
        last_data = 8'h00;
        reset_n = 1'b1;
        idle(3);
        read_all(); idle(3);

        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending reads, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
